// File: rtl/fir_mac_scheduler.sv
// fir_mac_scheduler
// -----------------------------------------------------------------------------
// Time-multiplexed direct-form FIR filter. A single 16x16 signed multiplier
// and a 48-bit accumulator are shared across all N taps. Each accepted sample
// takes N MAC cycles, and the scaled result is then presented on the output.
//
// Handshakes: a transfer happens on any rising clk edge where valid and ready
// are both high. The producer keeps valid and its data stable until that edge.
// in_ready depends only on the FSM state. out_valid and data_out are
// registered and held until out_ready is seen.
//
// Ports
//   clk, rst_n     clock and asynchronous active-low reset
//   coef_wr_en     write coef_wr_data into the shadow bank at coef_wr_addr
//   coef_wr_addr   tap index k (0 = newest sample); values >= N are ignored
//   coef_wr_data   signed coefficient b[k]
//   coef_swap      pulse that requests a shadow/active bank swap
//   swap_pending   a swap has been requested but not applied yet
//   in_valid       data_in is valid
//   in_ready       a sample can be accepted (state IDLE)
//   data_in        signed input sample
//   out_valid      data_out is valid
//   out_ready      downstream takes data_out
//   data_out       signed filtered sample, acc[47-div_N : 32-div_N]
//   busy           FSM is not in IDLE
// -----------------------------------------------------------------------------
module fir_mac_scheduler #(
  parameter int N     = 32,
  parameter int div_N = 16,
  localparam int AW   = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 coef_wr_en,
  input  logic [AW-1:0]        coef_wr_addr,
  input  logic signed [15:0]   coef_wr_data,
  input  logic                 coef_swap,
  output logic                 swap_pending,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [15:0]   data_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [15:0]   data_out,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(N - 1);
  localparam logic [AW:0]   N_W  = (AW + 1)'(N);

  state_t state, state_nxt;

  logic signed [15:0] hist  [N];
  logic signed [15:0] coef0 [N];
  logic signed [15:0] coef1 [N];

  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      tap;
  logic signed [47:0] acc;
  logic               active_bank;

  logic [AW-1:0]      wr_ptr_nxt;
  logic [AW-1:0]      rd_idx;
  logic signed [15:0] hist_rd;
  logic signed [15:0] coef_rd;
  logic signed [31:0] prod;
  logic signed [47:0] acc_sum;
  logic               addr_ok;
  logic               accept;
  logic               last_tap;

  // ---------------------------------------------------------------------------
  // FSM: state register and next-state logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = MAC;
      MAC:     if (last_tap)  state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = in_ready && in_valid;
  assign last_tap = (tap == LAST);

  // ---------------------------------------------------------------------------
  // Address arithmetic (all modulo N, N need not be a power of two)
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_nxt = (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
  end

  // Tap k reads the sample that arrived k samples before the newest one.
  always_comb begin
    if (wr_ptr >= tap) begin
      rd_idx = wr_ptr - tap;
    end else begin
      rd_idx = AW'({1'b0, wr_ptr} + N_W - {1'b0, tap});
    end
  end

  assign addr_ok = ({1'b0, coef_wr_addr} < N_W);

  // ---------------------------------------------------------------------------
  // Shared multiplier and accumulator
  // ---------------------------------------------------------------------------
  assign hist_rd = hist[rd_idx];
  assign coef_rd = active_bank ? coef1[tap] : coef0[tap];
  assign prod    = hist_rd * coef_rd;
  assign acc_sum = acc + {{16{prod[31]}}, prod};

  // ---------------------------------------------------------------------------
  // Datapath, coefficient banks and swap control
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        hist[i]  <= '0;
        coef0[i] <= '0;
        coef1[i] <= '0;
      end
      wr_ptr       <= '0;
      tap          <= '0;
      acc          <= '0;
      active_bank  <= 1'b0;
      swap_pending <= 1'b0;
      out_valid    <= 1'b0;
      data_out     <= '0;
    end else begin
      // Writes go to the bank that is inactive this cycle. When a swap is
      // applied in the same cycle, this is the bank that becomes active.
      if (coef_wr_en && addr_ok) begin
        if (active_bank) begin
          coef0[coef_wr_addr] <= coef_wr_data;
        end else begin
          coef1[coef_wr_addr] <= coef_wr_data;
        end
      end

      // A swap is applied only between samples, so every MAC run sees one
      // bank. Extra requests while one is pending collapse into that one.
      if ((state == IDLE) && swap_pending) begin
        active_bank  <= ~active_bank;
        swap_pending <= 1'b0;
      end else if (coef_swap) begin
        swap_pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            hist[wr_ptr_nxt] <= data_in;
            wr_ptr           <= wr_ptr_nxt;
            acc              <= '0;
            tap              <= '0;
          end
        end
        MAC: begin
          acc <= acc_sum;
          if (last_tap) begin
            tap       <= '0;
            data_out  <= acc_sum[47-div_N -: 16];
            out_valid <= 1'b1;
          end else begin
            tap <= tap + AW'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Testbench for fir_mac_scheduler (N=8, div_N=16).
// The reference model keeps the last N accepted samples and both coefficient
// banks as plain arrays. It computes each output as a direct 48-bit dot product
// when the sample is accepted. The DUT outputs are compared against it on every
// cycle, and the directed scenarios also carry hand-computed literal results.
module tb_fir_mac_scheduler;

  localparam int N    = 8;
  localparam int DIVN = 16;
  localparam int AW   = $clog2(N);
  localparam int SKIP = -999999;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                coef_wr_en;
  logic [AW-1:0]       coef_wr_addr;
  logic signed [15:0]  coef_wr_data;
  logic                coef_swap;
  logic                swap_pending;
  logic                in_valid;
  logic                in_ready;
  logic signed [15:0]  data_in;
  logic                out_valid;
  logic                out_ready;
  logic signed [15:0]  data_out;
  logic                busy;

  fir_mac_scheduler #(.N(N), .div_N(DIVN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .coef_wr_en   (coef_wr_en),
    .coef_wr_addr (coef_wr_addr),
    .coef_wr_data (coef_wr_data),
    .coef_swap    (coef_swap),
    .swap_pending (swap_pending),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .data_in      (data_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .data_out     (data_out),
    .busy         (busy)
  );

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic signed [15:0] exp_q[$];   // expected outputs of samples in flight
  int                 lit_q[$];   // hand-computed results, SKIP = none
  int                 m_hist[N];  // index 0 = newest accepted sample
  int                 m_bank[2][N];
  int                 m_act;
  bit                 m_pend, m_busy, m_ov;
  int                 m_cnt;
  logic signed [15:0] m_dout;

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_hist[k]    = 0;
      m_bank[0][k] = 0;
      m_bank[1][k] = 0;
    end
    m_act  = 0;
    m_pend = 0;
    m_busy = 0;
    m_ov   = 0;
    m_cnt  = 0;
    m_dout = '0;
    exp_q.delete();
  endtask

  task automatic model_step();
    longint      s;
    logic [47:0] a;
    if (coef_wr_en && int'(coef_wr_addr) < N)
      m_bank[1-m_act][int'(coef_wr_addr)] = int'(coef_wr_data);
    if (!m_busy && m_pend) begin
      m_act  = 1 - m_act;
      m_pend = 0;
    end else if (coef_swap) begin
      m_pend = 1;
    end
    if (!m_busy) begin
      if (in_valid) begin
        for (int k = N - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = int'(data_in);
        s = 0;
        for (int k = 0; k < N; k++)
          s += longint'(m_hist[k]) * longint'(m_bank[m_act][k]);
        a = s[47:0];
        exp_q.push_back(a[47-DIVN -: 16]);
        m_busy = 1;
        m_cnt  = 0;
      end
    end else if (!m_ov) begin
      m_cnt++;
      if (m_cnt == N) begin
        m_ov   = 1;
        m_dout = exp_q.pop_front();
      end
    end else if (out_ready) begin
      m_ov   = 0;
      m_busy = 0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // ---------------------------------------------------------------------------
  // Compare process (outputs sampled on the falling edge)
  // ---------------------------------------------------------------------------
  int cyc = 0, acc_cyc = -1, last_acc = -1, hs_cyc = -1, lit_v;
  bit prev_ov = 0, chk_period = 0, chk_gap = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      chk("in_ready",     int'(in_ready),     int'(!m_busy));
      chk("busy",         int'(busy),         int'(m_busy));
      chk("out_valid",    int'(out_valid),    int'(m_ov));
      chk("swap_pending", int'(swap_pending), int'(m_pend));
      chk("data_out",     int'(data_out),     int'(m_dout));
      if (in_valid && in_ready) begin
        if (chk_period && last_acc >= 0) chk("accept_period", cyc - last_acc, N + 2);
        if (chk_gap) chk("accept_after_release", cyc - hs_cyc, 1);
        last_acc = cyc;
        acc_cyc  = cyc;
      end
      if (out_valid && !prev_ov) chk("latency", cyc - acc_cyc, N + 1);
      if (out_valid && out_ready) begin
        hs_cyc = cyc;
        if (lit_q.size() > 0) begin
          lit_v = lit_q.pop_front();
          if (lit_v != SKIP) chk("literal_out", int'(data_out), lit_v);
        end
      end
      prev_ov = out_valid;
    end else begin
      prev_ov = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change 2 time units after the rising edge)
  // ---------------------------------------------------------------------------
  bit or_rand = 0, coef_rand = 0;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic signed [15:0] x, input int lit);
    int t = 0;
    lit_q.push_back(lit);
    in_valid = 1'b1;
    data_in  = x;
    while (!in_ready && t < 300) begin
      step();
      t++;
    end
    chk("send_timeout", int'(t < 300), 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wr_coef(input int k, input int v);
    coef_wr_en   = 1'b1;
    coef_wr_addr = AW'(k);
    coef_wr_data = 16'(v);
    step();
    coef_wr_en   = 1'b0;
  endtask

  task automatic pulse_swap();
    coef_swap = 1'b1;
    step();
    coef_swap = 1'b0;
  endtask

  task automatic wait_out_valid();
    int t = 0;
    while (!out_valid && t < 100) begin
      step();
      t++;
    end
    chk("wait_out_valid_timeout", int'(t < 100), 1);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((busy || out_valid) && t < 500) begin
      step();
      t++;
    end
    chk("drain_timeout", int'(t < 500), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    lit_q.delete();
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Random downstream backpressure.
  initial forever begin
    step();
    if (or_rand) out_ready = 1'($urandom_range(0, 1));
  end

  // Random coefficient traffic: writes and swap requests at any time.
  initial forever begin
    step();
    if (coef_rand) begin
      coef_wr_en   = ($urandom_range(0, 9) < 3);
      coef_wr_addr = AW'($urandom_range(0, N - 1));
      coef_wr_data = 16'($urandom_range(0, 65535));
      coef_swap    = ($urandom_range(0, 9) == 0);
    end
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  logic signed [15:0] held;

  initial begin
    in_valid = 1'b0; data_in = '0; out_ready = 1'b1;
    coef_wr_en = 1'b0; coef_wr_addr = '0; coef_wr_data = '0; coef_swap = 1'b0;
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Reset state
    chk("rst_out_valid",    int'(out_valid),    0);
    chk("rst_data_out",     int'(data_out),     0);
    chk("rst_in_ready",     int'(in_ready),     1);
    chk("rst_busy",         int'(busy),         0);
    chk("rst_swap_pending", int'(swap_pending), 0);

    // Impulse response: b[k] = 4*(k+1), x = 0x4000 then zeros
    for (int k = 0; k < N; k++) wr_coef(k, 4 * (k + 1));
    pulse_swap();
    send(16'sh4000, 1);
    for (int j = 2; j <= N; j++) send(16'sh0000, j);
    send(16'sh0000, 0);
    send(16'sh0000, 0);
    wait_drain();

    // Coefficient swap during a MAC run; the run in flight keeps the old bank
    out_ready = 1'b0;
    send(16'sh4000, 1);
    for (int k = 0; k < N; k++) wr_coef(k, 16'h2000);
    pulse_swap();
    step();
    pulse_swap();
    chk("swap_pending_held", int'(swap_pending), 1);
    chk("old_bank_out_valid", int'(out_valid), 1);
    chk("old_bank_data_out", int'(data_out), 1);
    out_ready = 1'b1;
    wait_drain();
    step();
    chk("swap_applied", int'(swap_pending), 0);
    send(16'sh4000, 4096);

    // Step response and throughput with in_valid and out_ready held high
    chk_period = 1'b1;
    last_acc   = -1;
    for (int j = 3; j <= N; j++) send(16'sh4000, 2048 * j);
    send(16'sh4000, 16384);
    send(16'sh4000, 16384);
    chk_period = 1'b0;
    wait_drain();

    // Backpressure: hold OUT for 20 cycles with the next sample waiting
    out_ready = 1'b0;
    send(16'sh1000, 14848);
    wait_out_valid();
    held     = data_out;
    in_valid = 1'b1;
    data_in  = 16'sh0800;
    repeat (20) step();
    chk("bp_out_valid", int'(out_valid), 1);
    chk("bp_data_out",  int'(data_out),  int'(held));
    chk("bp_in_ready",  int'(in_ready),  0);
    chk_gap   = 1'b1;
    out_ready = 1'b1;
    send(16'sh0800, 13056);
    chk_gap = 1'b0;
    wait_drain();

    // Full-scale products wrap: 8 * 2^30 = 2^33 -> acc[31:16] = 0
    for (int k = 0; k < N; k++) wr_coef(k, -32768);
    pulse_swap();
    for (int j = 0; j < N - 1; j++) send(-16'sd32768, SKIP);
    send(-16'sd32768, 0);
    wait_drain();

    // Randomized traffic
    or_rand   = 1'b1;
    coef_rand = 1'b1;
    for (int j = 0; j < 40; j++) begin
      repeat ($urandom_range(0, 3)) step();
      send(16'($urandom_range(0, 65535)), SKIP);
    end
    coef_rand = 1'b0;
    coef_wr_en = 1'b0;
    coef_swap  = 1'b0;
    or_rand   = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    step();

    // Reset at tap 3 discards the partial result and clears the banks
    for (int k = 0; k < N; k++) wr_coef(k, 4 * (k + 1));
    pulse_swap();
    send(16'sh4000, SKIP);
    repeat (3) step();
    do_reset();
    chk("rst2_out_valid", int'(out_valid), 0);
    chk("rst2_data_out",  int'(data_out),  0);
    chk("rst2_in_ready",  int'(in_ready),  1);
    send(16'sh4000, 0);
    send(16'sh0000, 0);
    wait_drain();

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
